// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time over req/ack, fixed-latency completion.
// Optional stuck-at read-data fault injector enabled by defining MEM_FAULT_INJECT_EN.
module mem_responder #(
    parameter int                      p_DATA_WIDTH = 8,
    parameter int                      p_ADDR_WIDTH = 4,
    parameter int                      p_LATENCY    = 2,
    parameter logic [p_DATA_WIDTH-1:0] p_INIT_DATA  = '0
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_REQ,
    input  logic                    i_WE,
    input  logic [p_ADDR_WIDTH-1:0] i_ADDR,
    input  logic [p_DATA_WIDTH-1:0] i_WDATA,
`ifdef MEM_FAULT_INJECT_EN
    input  logic                    i_FAULT_EN,
    input  logic [p_DATA_WIDTH-1:0] i_FAULT_MASK,
    input  logic [p_DATA_WIDTH-1:0] i_FAULT_VAL,
`endif
    output logic                    o_ACK,
    output logic [p_DATA_WIDTH-1:0] o_RDATA,
    output logic                    o_BUSY
);

    localparam int c_DEPTH = 2 ** p_ADDR_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [3:0] c_CNT_INIT = (p_LATENCY >= 2) ? 4'(p_LATENCY - 2) : 4'd0;

    logic [1:0]              state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    accept;
    logic                    enter_ack;

    logic                    we_q;
    logic [p_ADDR_WIDTH-1:0] addr_q;
    logic [p_DATA_WIDTH-1:0] wdata_q;

    logic                    op_we;
    logic [p_ADDR_WIDTH-1:0] op_addr;
    logic [p_DATA_WIDTH-1:0] op_wdata;
    logic [p_DATA_WIDTH-1:0] rd_word;

    logic [p_DATA_WIDTH-1:0] mem [c_DEPTH];

    assign accept = (state_q == S_IDLE) && i_REQ;

    // With p_LATENCY=1 the array is touched on the acceptance edge itself,
    // so the operation fields bypass the request latches in that case.
    assign op_we    = accept ? i_WE    : we_q;
    assign op_addr  = accept ? i_ADDR  : addr_q;
    assign op_wdata = accept ? i_WDATA : wdata_q;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        enter_ack = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_REQ) begin
                    if (p_LATENCY == 1) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = c_CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = S_ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= i_WE;
                addr_q  <= i_ADDR;
                wdata_q <= i_WDATA;
            end
        end
    end

    always_comb begin
        rd_word = mem[op_addr];
`ifdef MEM_FAULT_INJECT_EN
        if (i_FAULT_EN) begin
            rd_word = (rd_word & ~i_FAULT_MASK) | (i_FAULT_VAL & i_FAULT_MASK);
        end
`endif
    end

    // NOTE: the array must reinitialise on reset, so it is built from resettable
    // flops rather than an inferred RAM macro (which has no reset).
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                mem[i] <= p_INIT_DATA;
            end
        end else if (enter_ack && op_we) begin
            mem[op_addr] <= op_wdata;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_RDATA <= p_INIT_DATA;
        end else if (enter_ack && !op_we) begin
            o_RDATA <= rd_word;
        end
    end

    assign o_ACK  = (state_q == S_ACK);
    assign o_BUSY = (state_q != S_IDLE);

endmodule
